// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port synchronous RAM between the
//               instruction-fetch port (i_*) and the load/store port (d_*).
//               At most one access is granted per cycle. Data normally wins
//               over fetch; a fetch that has been stalled for MAX_WAIT
//               consecutive cycles wins instead. Read data comes back one
//               cycle after the grant, to the port that issued the read.
//
// Parameters  : DEPTH    - RAM depth in 32-bit words
//               ADDR_W   - RAM word-address width, equal to clog2(DEPTH)
//               MAX_WAIT - stalled fetch cycles before fetch wins (1..255)
//               WORD_LEN - data / byte-address width
//
// Ports       : clk, rst_n                     clock, sync active-low reset
//               i_req, i_addr, i_kill          fetch request / flush
//               i_gnt, i_rvalid, i_rdata       fetch grant / response
//               d_req, d_we, d_addr, d_wdata   data request
//               d_gnt, d_rvalid, d_rdata       data grant / response
//               mem_addr, mem_wen, mem_wdata   RAM drive
//               mem_rdata                      RAM read data (1-cycle latency)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DEPTH    = 4096,
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 4,
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                i_req,
    input  logic [WORD_LEN-1:0] i_addr,
    input  logic                i_kill,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [WORD_LEN-1:0] i_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WORD_LEN-1:0] d_rdata,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    // In-flight read owner encoding
    localparam logic [1:0] c_OWN_NONE   = 2'd0;
    localparam logic [1:0] c_OWN_IFETCH = 2'd1;
    localparam logic [1:0] c_OWN_DLOAD  = 2'd2;

    localparam logic [7:0] c_MAX_WAIT   = 8'(MAX_WAIT);

    logic [1:0]        r_owner;
    logic [7:0]        r_wait_cnt;

    logic              w_fetch_starved;
    logic              w_i_gnt;
    logic              w_d_gnt;
    logic [ADDR_W-1:0] w_i_word;
    logic [ADDR_W-1:0] w_d_word;

    // Byte-offset bits and address bits above the RAM are deliberately
    // dropped (addresses wrap within the RAM).
    logic              w_unused_bits;
    assign w_unused_bits = ^{i_addr[WORD_LEN-1:ADDR_W+2], i_addr[1:0],
                             d_addr[WORD_LEN-1:ADDR_W+2], d_addr[1:0]};

    assign w_i_word = i_addr[ADDR_W+1:2];
    assign w_d_word = d_addr[ADDR_W+1:2];

    // ------------------------------------------------------------------
    // Arbitration: data has priority unless fetch has waited MAX_WAIT
    // cycles. Grants are suppressed while reset is asserted.
    // ------------------------------------------------------------------
    assign w_fetch_starved = (r_wait_cnt == c_MAX_WAIT);
    assign w_i_gnt         = rst_n & i_req & (~d_req | w_fetch_starved);
    assign w_d_gnt         = rst_n & d_req & ~w_i_gnt;

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    // ------------------------------------------------------------------
    // RAM drive. With no data grant the fetch address is presented, which
    // also covers the idle case.
    // ------------------------------------------------------------------
    assign mem_addr  = w_d_gnt ? w_d_word : w_i_word;
    assign mem_wen   = w_d_gnt & d_we;
    assign mem_wdata = d_wdata;

    // ------------------------------------------------------------------
    // Fetch wait counter and in-flight owner
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
            r_owner    <= c_OWN_NONE;
        end else begin
            if (!i_req || w_i_gnt) begin
                r_wait_cnt <= 8'd0;
            end else if (r_wait_cnt != c_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            if (w_i_gnt) begin
                r_owner <= c_OWN_IFETCH;
            end else if (w_d_gnt && !d_we) begin
                r_owner <= c_OWN_DLOAD;
            end else begin
                r_owner <= c_OWN_NONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Responses. Gating with rst_n drops a response whose read was granted
    // in the cycle just before reset was asserted.
    // ------------------------------------------------------------------
    assign i_rvalid = rst_n & (r_owner == c_OWN_IFETCH) & ~i_kill;
    assign d_rvalid = rst_n & (r_owner == c_OWN_DLOAD);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A synchronous RAM model
//               sits behind the arbiter; a behavioural reference model keeps
//               a shadow memory and the expected pending response, and checks
//               all outputs every cycle. Directed sequences pin literal values,
//               followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst_n;
    logic        i_req, i_kill, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [11:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_err    = 0;

    mem_arbiter #(
        .DEPTH    (4096),
        .ADDR_W   (12),
        .MAX_WAIT (MAX_WAIT),
        .WORD_LEN (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_kill    (i_kill),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Synchronous RAM: word i initially holds 0x1000_0000 + i.
    // ------------------------------------------------------------------
    logic [31:0] ram [0:4095];
    logic        ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int k = 0; k < 4096; k++) ram[k] <= 32'h1000_0000 + 32'(k);
            ram_ready <= 1'b1;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_wen) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] word_of(input logic [31:0] a);
        return a[13:2];
    endfunction

    // ------------------------------------------------------------------
    // Reference model, evaluated mid-cycle (negedge) when inputs are
    // stable; its state then advances to represent the coming rising edge.
    // ------------------------------------------------------------------
    logic [31:0] sh [0:4095];
    int          m_pend;      // 0 none, 1 fetch response, 2 load response
    logic [31:0] m_pdata;
    int          m_wait;
    logic        e_ig, e_dg;

    initial begin
        for (int k = 0; k < 4096; k++) sh[k] = 32'h1000_0000 + 32'(k);
        m_pend = 0;
        m_wait = 0;
        m_pdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk1("rst_i_gnt", i_gnt, 1'b0);
                chk1("rst_d_gnt", d_gnt, 1'b0);
                chk1("rst_mem_wen", mem_wen, 1'b0);
                chk1("rst_i_rvalid", i_rvalid, 1'b0);
                chk1("rst_d_rvalid", d_rvalid, 1'b0);
                m_pend = 0;
                m_wait = 0;
            end else begin
                e_ig = i_req && (!d_req || (m_wait == MAX_WAIT));
                e_dg = d_req && !e_ig;
                chk1("m_i_gnt", i_gnt, e_ig);
                chk1("m_d_gnt", d_gnt, e_dg);
                chk1("m_mem_wen", mem_wen, e_dg && d_we);
                chk32("m_mem_wdata", mem_wdata, d_wdata);
                chk32("m_mem_addr", {20'h0, mem_addr},
                      {20'h0, e_dg ? word_of(d_addr) : word_of(i_addr)});
                chk1("m_i_rvalid", i_rvalid, (m_pend == 1) && !i_kill);
                chk1("m_d_rvalid", d_rvalid, m_pend == 2);
                if (m_pend == 1) chk32("m_i_rdata", i_rdata, m_pdata);
                if (m_pend == 2) chk32("m_d_rdata", d_rdata, m_pdata);

                if (e_dg && d_we) sh[word_of(d_addr)] = d_wdata;
                if (e_ig) begin
                    m_pend  = 1;
                    m_pdata = sh[word_of(i_addr)];
                end else if (e_dg && !d_we) begin
                    m_pend  = 2;
                    m_pdata = sh[word_of(d_addr)];
                end else begin
                    m_pend = 0;
                end
                if (!i_req || e_ig)         m_wait = 0;
                else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after the rising edge; directed
    // checks look 2 units later, well before the next edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic last_ig, last_dg;

    initial begin
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = 32'h0; i_kill = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h1234_5678;

        // Reset with both ports requesting
        repeat (3) tick();
        #2;
        chk1("reset_i_gnt", i_gnt, 1'b0);
        chk1("reset_d_gnt", d_gnt, 1'b0);
        chk1("reset_mem_wen", mem_wen, 1'b0);
        chk1("reset_i_rvalid", i_rvalid, 1'b0);
        chk1("reset_d_rvalid", d_rvalid, 1'b0);
        tick();
        rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #2;
        chk1("release_i_rvalid", i_rvalid, 1'b0);
        chk1("release_d_rvalid", d_rvalid, 1'b0);

        // Fetch 0x0, 0x4, 0x8
        tick(); i_req = 1'b1; i_addr = 32'h0;
        #2; chk1("f0_gnt", i_gnt, 1'b1); chk32("f0_addr", {20'h0, mem_addr}, 32'h0);
        tick(); i_addr = 32'h4;
        #2; chk1("f1_gnt", i_gnt, 1'b1); chk32("f1_addr", {20'h0, mem_addr}, 32'h1);
        chk1("f0_rvalid", i_rvalid, 1'b1); chk32("f0_rdata", i_rdata, 32'h1000_0000);
        tick(); i_addr = 32'h8;
        #2; chk32("f2_addr", {20'h0, mem_addr}, 32'h2);
        chk1("f1_rvalid", i_rvalid, 1'b1); chk32("f1_rdata", i_rdata, 32'h1000_0001);
        tick(); i_req = 1'b0;
        #2; chk1("f3_gnt", i_gnt, 1'b0);
        chk1("f2_rvalid", i_rvalid, 1'b1); chk32("f2_rdata", i_rdata, 32'h1000_0002);

        // Store then load the same address
        tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        #2; chk1("st_gnt", d_gnt, 1'b1); chk1("st_wen", mem_wen, 1'b1);
        chk32("st_addr", {20'h0, mem_addr}, 32'h10);
        tick(); d_we = 1'b0;
        #2; chk1("st_no_rvalid", d_rvalid, 1'b0); chk1("ld_gnt", d_gnt, 1'b1);
        chk1("ld_wen", mem_wen, 1'b0);
        tick(); d_req = 1'b0;
        #2; chk1("ld_rvalid", d_rvalid, 1'b1); chk32("ld_rdata", d_rdata, 32'hDEAD_BEEF);

        // Both requesting continuously: 4 data grants then 1 fetch, repeated
        tick(); i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int k = 0; k < 10; k++) begin
            #2;
            chk1("bw_i_gnt", i_gnt, (k % 5) == 4);
            chk1("bw_d_gnt", d_gnt, (k % 5) != 4);
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;

        // Kill the response of a fetch; the following fetch still returns
        tick(); i_req = 1'b1; i_addr = 32'hC;
        #2; chk1("k0_gnt", i_gnt, 1'b1);
        tick(); i_kill = 1'b1; i_addr = 32'h10;
        #2; chk1("k_rvalid_killed", i_rvalid, 1'b0); chk1("k1_gnt", i_gnt, 1'b1);
        tick(); i_kill = 1'b0; i_req = 1'b0;
        #2; chk1("k1_rvalid", i_rvalid, 1'b1); chk32("k1_rdata", i_rdata, 32'h1000_0004);

        // Reset right after a load grant drops the response
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        #2; chk1("rl_gnt", d_gnt, 1'b1);
        tick(); d_req = 1'b0; rst_n = 1'b0;
        #2; chk1("rl_rvalid_dropped", d_rvalid, 1'b0);
        tick(); rst_n = 1'b1;
        #2; chk1("rl_after_d", d_rvalid, 1'b0); chk1("rl_after_i", i_rvalid, 1'b0);
        tick();
        #2; chk1("rl_after2_d", d_rvalid, 1'b0);

        // Byte offset ignored, upper address bits wrap
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h43;
        #2; chk32("a43_addr", {20'h0, mem_addr}, 32'h10);
        tick(); d_addr = 32'h4000;
        #2; chk32("a4000_addr", {20'h0, mem_addr}, 32'h0);
        chk32("a43_rdata", d_rdata, 32'hDEAD_BEEF);
        tick(); d_req = 1'b0;
        #2; chk1("a4000_rvalid", d_rvalid, 1'b1); chk32("a4000_rdata", d_rdata, 32'h1000_0000);

        // Randomized traffic, obeying hold-until-grant
        last_ig = 1'b0; last_dg = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 99) >= 2);
            if (!i_req || last_ig) begin
                i_req  = ($urandom_range(0, 99) < 65);
                i_addr = $urandom & 32'h0000_403F;
            end else if ($urandom_range(0, 99) < 3) begin
                i_req = 1'b0;
            end
            if (!d_req || last_dg) begin
                d_req   = ($urandom_range(0, 99) < 60);
                d_we    = ($urandom_range(0, 1) == 1);
                d_addr  = $urandom & 32'h0000_403F;
                d_wdata = $urandom;
            end else if ($urandom_range(0, 99) < 3) begin
                d_req = 1'b0;
            end
            i_kill = ($urandom_range(0, 99) < 15);
            #2;
            last_ig = i_gnt;
            last_dg = d_gnt;
        end

        i_req = 1'b0; d_req = 1'b0; i_kill = 1'b0; rst_n = 1'b1;
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
